// File: rtl/ysyx_23060124_arb_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter.
//   arb_state_t : arbiter FSM states
//   OKAY/SLVERR : AXI response codes (passed through, never interpreted)
//   IFU/LSU     : requester IDs, also the bit index into req/grant vectors
package ysyx_23060124_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IFU_AR,
        IFU_R,
        LSU_AR,
        LSU_R,
        LSU_AW,
        LSU_B
    } arb_state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic IFU = 1'b0;
    localparam logic LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060124_rr_arb2.sv
// Two-way round-robin picker.
//   req[1:0]   : pending requests, bit IFU (0) and bit LSU (1)
//   last       : ID of the requester granted most recently
//   grant[1:0] : one-hot winner (all zero when nothing is pending)
module ysyx_23060124_rr_arb2
    import ysyx_23060124_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        // On a tie, whoever was not served last goes first.
        if (req == 2'b11) begin
            grant = (last == IFU) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ysyx_23060124_mem_arbiter.sv
// Serialises IFU fetches and LSU loads/stores onto one AXI4-Lite SRAM port.
// One transaction in flight at a time; IFU and LSU are granted round-robin.
//   M_AXI_ACLK, ifu_rst   : clock, asynchronous active-low reset
//   ifu_ar*/ifu_r*        : IFU read channels (slave side of the arbiter)
//   lsu_ar*/lsu_r*        : LSU read channels
//   lsu_aw*/lsu_w*/lsu_b* : LSU write channels
//   m_*                   : master port towards the shared SRAM
//   o_timeout             : sticky, slave stalled for TIMEOUT cycles in one state
//   o_busy                : arbiter not idle
module ysyx_23060124_mem_arbiter
    import ysyx_23060124_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                M_AXI_ACLK,
    input  logic                ifu_rst,

    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,

    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,

    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    output logic [1:0]          lsu_bresp,

    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,

    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp,

    output logic                o_timeout,
    output logic                o_busy
);

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    arb_state_t  state, state_next;
    logic        last_grant;
    logic [1:0]  req, grant;
    logic        grant_ok, ifu_grant, lsu_grant;
    logic        waiting;
    logic [15:0] to_cnt;

    assign req = {lsu_arvalid | (lsu_awvalid & lsu_wvalid), ifu_arvalid};

    ysyx_23060124_rr_arb2 u_rr (
        .req   (req),
        .last  (last_grant),
        .grant (grant)
    );

    // Readies are gated by reset so a requester never sees a grant
    // that the (reset-held) registers cannot accept.
    assign grant_ok  = (state == IDLE) && ifu_rst;
    assign ifu_grant = grant_ok && grant[0];
    assign lsu_grant = grant_ok && grant[1];
    assign o_busy    = (state != IDLE);

    always_comb begin
        state_next  = state;
        ifu_arready = 1'b0;
        lsu_arready = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        m_rready    = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        m_bready    = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_bresp   = '0;
        waiting     = 1'b0;
        case (state)
            IDLE: begin
                if (ifu_grant) begin
                    ifu_arready = 1'b1;
                    state_next  = IFU_AR;
                end else if (lsu_grant) begin
                    // A pending LSU read takes precedence over its write.
                    if (lsu_arvalid) begin
                        lsu_arready = 1'b1;
                        state_next  = LSU_AR;
                    end else begin
                        lsu_awready = 1'b1;
                        lsu_wready  = 1'b1;
                        state_next  = LSU_AW;
                    end
                end
            end
            IFU_AR, LSU_AR: begin
                waiting = !(m_arvalid && m_arready);
                if (m_arvalid && m_arready) begin
                    state_next = (state == IFU_AR) ? IFU_R : LSU_R;
                end
            end
            IFU_R: begin
                m_rready   = ifu_rready;
                ifu_rvalid = m_rvalid;
                ifu_rdata  = m_rdata;
                ifu_rresp  = m_rresp;
                waiting    = !(m_rvalid && ifu_rready);
                if (m_rvalid && ifu_rready) begin
                    state_next = IDLE;
                end
            end
            LSU_R: begin
                m_rready   = lsu_rready;
                lsu_rvalid = m_rvalid;
                lsu_rdata  = m_rdata;
                lsu_rresp  = m_rresp;
                waiting    = !(m_rvalid && lsu_rready);
                if (m_rvalid && lsu_rready) begin
                    state_next = IDLE;
                end
            end
            LSU_AW: begin
                waiting = !((m_awvalid && m_awready) || (m_wvalid && m_wready));
                // Each valid is dropped independently; leave once neither
                // channel still has an outstanding beat after this cycle.
                if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
                    state_next = LSU_B;
                end
            end
            LSU_B: begin
                m_bready   = lsu_bready;
                lsu_bvalid = m_bvalid;
                lsu_bresp  = m_bresp;
                waiting    = !(m_bvalid && lsu_bready);
                if (m_bvalid && lsu_bready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge ifu_rst) begin
        if (!ifu_rst) begin
            state      <= IDLE;
            last_grant <= LSU;
            m_arvalid  <= 1'b0;
            m_araddr   <= '0;
            m_awvalid  <= 1'b0;
            m_awaddr   <= '0;
            m_wvalid   <= 1'b0;
            m_wdata    <= '0;
            m_wstrb    <= '0;
        end else begin
            state <= state_next;
            if (ifu_grant) begin
                last_grant <= IFU;
                m_araddr   <= ifu_araddr;
                m_arvalid  <= 1'b1;
            end else if (lsu_grant) begin
                last_grant <= LSU;
                if (lsu_arvalid) begin
                    m_araddr  <= lsu_araddr;
                    m_arvalid <= 1'b1;
                end else begin
                    m_awaddr  <= lsu_awaddr;
                    m_wdata   <= lsu_wdata;
                    m_wstrb   <= lsu_wstrb;
                    m_awvalid <= 1'b1;
                    m_wvalid  <= 1'b1;
                end
            end
            if (m_arvalid && m_arready) m_arvalid <= 1'b0;
            if (m_awvalid && m_awready) m_awvalid <= 1'b0;
            if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
        end
    end

    // Flag is raised on the edge that completes the TIMEOUT-th waiting cycle.
    always_ff @(posedge M_AXI_ACLK or negedge ifu_rst) begin
        if (!ifu_rst) begin
            to_cnt    <= '0;
            o_timeout <= 1'b0;
        end else if (state_next != state) begin
            to_cnt <= '0;
        end else if (waiting) begin
            if (to_cnt != TO_LIMIT) to_cnt <= to_cnt + 16'd1;
            if (to_cnt == TO_LIMIT - 16'd1) o_timeout <= 1'b1;
        end
    end

endmodule
